// File: rtl/icg_wake_scheduler.sv
// Power controller for clock-gated register banks: wakes banks one at a time
// with a settle period, and gates each bank off after a run of idle cycles.
module icg_wake_scheduler #(
    parameter int NUM_CH   = 4,
    parameter int WAKE_CYC = 2,
    parameter int IDLE_CYC = 8,
    parameter int CNT_W    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              req,
    input  logic                           force_on,
    output logic [NUM_CH-1:0]              gate_en,
    output logic [NUM_CH-1:0]              ready,
    output logic [NUM_CH-1:0]              wake_grant,
    output logic                           wake_busy,
    output logic [$clog2(NUM_CH+1)-1:0]    n_active
);

    localparam int RR_W = $clog2(NUM_CH);
    localparam int NA_W = $clog2(NUM_CH + 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);

    typedef enum logic [1:0] {
        CH_OFF  = 2'd0,
        CH_PEND = 2'd1,
        CH_WAKE = 2'd2,
        CH_ON   = 2'd3
    } ch_state_t;

    ch_state_t             state_r     [NUM_CH];
    ch_state_t             state_nxt_s [NUM_CH];
    logic [CNT_W-1:0]      cnt_r       [NUM_CH];
    logic [CNT_W-1:0]      cnt_nxt_s   [NUM_CH];
    logic [RR_W-1:0]       rr_r;
    logic [NUM_CH-1:0]     r_s;
    logic [NUM_CH-1:0]     elig_s;
    logic [NUM_CH-1:0]     in_wake_s;
    logic                  any_wake_s;
    logic                  grant_vld_s;
    logic [RR_W-1:0]       grant_idx_s;
    logic [NUM_CH-1:0]     grant_s;
    logic [NUM_CH-1:0]     gate_nxt_s;
    logic [NUM_CH-1:0]     ready_nxt_s;
    logic                  busy_nxt_s;
    logic [NUM_CH-1:0]     gate_en_r;
    logic [NUM_CH-1:0]     ready_r;
    logic [NUM_CH-1:0]     wake_grant_r;
    logic                  wake_busy_r;
    logic [NA_W-1:0]       n_active_r;

    function automatic logic [RR_W-1:0] rr_wrap(input logic [RR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CH) begin
            s = s - NUM_CH;
        end else begin
            s = s;
        end
        return RR_W'(s);
    endfunction

    function automatic logic [NA_W-1:0] popcount(input logic [NUM_CH-1:0] v);
        logic [NA_W-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            s = s + NA_W'(v[i]);
        end
        return s;
    endfunction

    // Effective requests and arbiter eligibility; cancelling channels are excluded
    always_comb begin
        r_s = req | {NUM_CH{force_on}};
        for (int i = 0; i < NUM_CH; i++) begin
            elig_s[i]    = (state_r[i] == CH_PEND) && r_s[i];
            in_wake_s[i] = (state_r[i] == CH_WAKE);
        end
        any_wake_s = |in_wake_s;
    end

    // Single-slot round-robin wake arbiter scanning upward from rr
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        grant_s     = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            if (!grant_vld_s && !any_wake_s && elig_s[rr_wrap(rr_r, off)]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = rr_wrap(rr_r, off);
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
        if (grant_vld_s) begin
            grant_s[grant_idx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    // Per-channel next state; one counter serves as wake timer and idle run length
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_nxt_s[i] = state_r[i];
            cnt_nxt_s[i]   = cnt_r[i];
            case (state_r[i])
                CH_OFF: begin
                    if (r_s[i]) state_nxt_s[i] = CH_PEND;
                    else        state_nxt_s[i] = CH_OFF;
                end
                CH_PEND: begin
                    if (!r_s[i]) begin
                        state_nxt_s[i] = CH_OFF;
                    end else if (grant_s[i]) begin
                        state_nxt_s[i] = CH_WAKE;
                        cnt_nxt_s[i]   = '0;
                    end else begin
                        state_nxt_s[i] = CH_PEND;
                    end
                end
                CH_WAKE: begin
                    if (cnt_r[i] == WAKE_LAST) begin
                        state_nxt_s[i] = CH_ON;
                        cnt_nxt_s[i]   = '0;
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
                    end
                end
                CH_ON: begin
                    if (r_s[i]) begin
                        cnt_nxt_s[i] = '0;
                    end else if (cnt_r[i] == IDLE_LAST) begin
                        state_nxt_s[i] = CH_OFF;
                        cnt_nxt_s[i]   = '0;
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt_s[i] = CH_OFF;
                    cnt_nxt_s[i]   = '0;
                end
            endcase
        end
    end

    // Output values decoded from next state so they register alongside it
    always_comb begin
        busy_nxt_s = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            gate_nxt_s[i]  = (state_nxt_s[i] == CH_WAKE) || (state_nxt_s[i] == CH_ON);
            ready_nxt_s[i] = (state_nxt_s[i] == CH_ON);
            busy_nxt_s     = busy_nxt_s | (state_nxt_s[i] == CH_WAKE);
        end
    end

    // State, pointer and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_r[i] <= CH_OFF;
                cnt_r[i]   <= '0;
            end
            rr_r         <= '0;
            gate_en_r    <= '0;
            ready_r      <= '0;
            wake_grant_r <= '0;
            wake_busy_r  <= 1'b0;
            n_active_r   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_r[i] <= state_nxt_s[i];
                cnt_r[i]   <= cnt_nxt_s[i];
            end
            if (grant_vld_s) begin
                rr_r <= rr_wrap(grant_idx_s, 1);
            end else begin
                rr_r <= rr_r;
            end
            gate_en_r    <= gate_nxt_s;
            ready_r      <= ready_nxt_s;
            wake_grant_r <= grant_s;
            wake_busy_r  <= busy_nxt_s;
            n_active_r   <= popcount(gate_nxt_s);
        end
    end

    assign gate_en    = gate_en_r;
    assign ready      = ready_r;
    assign wake_grant = wake_grant_r;
    assign wake_busy  = wake_busy_r;
    assign n_active   = n_active_r;

endmodule

// File: tb/tb_icg_wake_scheduler.sv
// Scoreboard bench: a cycle-level behavioural model pushes expected outputs,
// a negedge monitor pops and compares them against the scheduler.
module tb_icg_wake_scheduler;

    localparam int NUM_CH   = 4;
    localparam int WAKE_CYC = 2;
    localparam int IDLE_CYC = 8;
    localparam int CNT_W    = 4;
    localparam int NA_W     = $clog2(NUM_CH + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_CH-1:0]    req;
    logic                 force_on;
    logic [NUM_CH-1:0]    gate_en;
    logic [NUM_CH-1:0]    ready;
    logic [NUM_CH-1:0]    wake_grant;
    logic                 wake_busy;
    logic [NA_W-1:0]      n_active;

    icg_wake_scheduler #(
        .NUM_CH(NUM_CH), .WAKE_CYC(WAKE_CYC), .IDLE_CYC(IDLE_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .force_on(force_on),
        .gate_en(gate_en), .ready(ready), .wake_grant(wake_grant),
        .wake_busy(wake_busy), .n_active(n_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH-1:0] gate;
        logic [NUM_CH-1:0] rdy;
        logic [NUM_CH-1:0] grant;
        logic              busy;
        logic [NA_W-1:0]   nact;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Model state: which banks run, which wait, the single wake in flight
    logic [NUM_CH-1:0] m_on;
    logic [NUM_CH-1:0] m_pend;
    int                m_idle [NUM_CH];
    int                m_wake_ch;
    int                m_wake_done;
    int                m_rr;

    // Behavioural reference model, advanced once per rising edge
    always @(posedge clk) begin : model
        exp_t              e;
        logic [NUM_CH-1:0] r;
        logic [NUM_CH-1:0] snap_on;
        logic [NUM_CH-1:0] snap_pend;
        int                snap_wake;
        int                win;
        if (rst) begin
            m_on = '0; m_pend = '0; m_wake_ch = -1; m_wake_done = 0; m_rr = 0;
            for (int c = 0; c < NUM_CH; c++) m_idle[c] = 0;
            e.gate = '0; e.rdy = '0; e.grant = '0; e.busy = 1'b0; e.nact = '0;
        end else begin
            r   = req | {NUM_CH{force_on}};
            win = -1;
            if (m_wake_ch < 0) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    int c;
                    c = (m_rr + k) % NUM_CH;
                    if (win < 0 && m_pend[c] && r[c]) win = c;
                end
            end
            snap_on = m_on; snap_pend = m_pend; snap_wake = m_wake_ch;
            if (snap_wake >= 0) begin
                m_wake_done++;
                if (m_wake_done == WAKE_CYC) begin
                    m_on[snap_wake] = 1'b1;
                    m_idle[snap_wake] = 0;
                    m_wake_ch = -1;
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (snap_on[c]) begin
                    if (r[c]) m_idle[c] = 0;
                    else begin
                        m_idle[c]++;
                        if (m_idle[c] == IDLE_CYC) m_on[c] = 1'b0;
                    end
                end else if (snap_pend[c]) begin
                    if (!r[c]) m_pend[c] = 1'b0;
                    else if (win == c) begin
                        m_pend[c] = 1'b0; m_wake_ch = c; m_wake_done = 0;
                        m_rr = (c + 1) % NUM_CH;
                    end
                end else if (c != snap_wake && r[c]) begin
                    m_pend[c] = 1'b1;
                end
            end
            e.grant = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                e.gate[c] = m_on[c] || (m_wake_ch == c);
                if (win == c) e.grant[c] = 1'b1;
            end
            e.rdy  = m_on;
            e.busy = (m_wake_ch >= 0);
            e.nact = NA_W'($countones(e.gate));
        end
        exp_q.push_back(e);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: one expected record per cycle, compared away from the active edge
    always @(negedge clk) begin : monitor
        exp_t e;
        cyc++;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty cycle=%0d got=0 expected=1", cyc);
        end else begin
            e = exp_q.pop_front();
            chk("gate_en",    32'(gate_en),    32'(e.gate));
            chk("ready",      32'(ready),      32'(e.rdy));
            chk("wake_grant", 32'(wake_grant), 32'(e.grant));
            chk("wake_busy",  32'(wake_busy),  32'(e.busy));
            chk("n_active",   32'(n_active),   32'(e.nact));
        end
    end

    task automatic drive(input logic [NUM_CH-1:0] r, input logic f, input logic rs, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            req = r; force_on = f; rst = rs;
        end
    endtask

    initial begin
        logic [NUM_CH-1:0] rv;
        rst = 1'b1; req = '0; force_on = 1'b0;
        drive(4'b0000, 1'b0, 1'b1, 3);
        // single channel wake then idle gate-off
        drive(4'b0001, 1'b0, 1'b0, 10);
        drive(4'b0000, 1'b0, 1'b0, 14);
        // serialized wake of all channels
        drive(4'b1111, 1'b0, 1'b0, 20);
        drive(4'b0000, 1'b0, 1'b0, 12);
        // round-robin: ch2 first, then ch0 and ch3 while ch2 wakes
        drive(4'b0100, 1'b0, 1'b0, 3);
        drive(4'b1101, 1'b0, 1'b0, 12);
        drive(4'b0000, 1'b0, 1'b0, 12);
        // cancel: one-edge pulse on ch1 while ch0 wakes
        drive(4'b0001, 1'b0, 1'b0, 2);
        drive(4'b0011, 1'b0, 1'b0, 1);
        drive(4'b0001, 1'b0, 1'b0, 6);
        drive(4'b0000, 1'b0, 1'b0, 12);
        // force_on held then released
        drive(4'b0000, 1'b1, 1'b0, 40);
        drive(4'b0000, 1'b0, 1'b0, 12);
        // reset during a wake with other channels on and pending
        drive(4'b0111, 1'b0, 1'b0, 6);
        drive(4'b0111, 1'b0, 1'b1, 1);
        drive(4'b0111, 1'b0, 1'b0, 14);
        drive(4'b0000, 1'b0, 1'b0, 12);
        // random traffic with long request runs, occasional force and reset
        rv = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 9) == 0) rv[c] = ~rv[c];
            end
            drive(rv, ($urandom_range(0, 49) == 0), ($urandom_range(0, 299) == 0), 1);
        end
        drive(4'b0000, 1'b0, 1'b0, 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
